// File: rtl/icache_flush_ctrl_if.sv
// ----------------------------------------------------------------------------
// icache_flush_ctrl_if
//   Bundles every non-clock, non-reset signal of the icache refill controller.
//
//   Core / line side:
//     icache_rdreq, icache_addr     core read request and byte address
//     line_miss                     per-line miss flags (bit i = line i)
//     line_ttl                      packed TTLs, line i at [i*TTLBITS +: TTLBITS]
//     flush_mode                    one-hot victim line under fill
//     flush_we, flush_addr, flush_in  write strobe, byte address, data
//     fill_busy, fill_done          fill in progress / one-cycle completion pulse
//   Memory side:
//     mem_rdreq, mem_addr           read request (held until data), word-aligned address
//     mem_rdata, mem_rdata_valid    returned word and its valid strobe
//
//   Modports:
//     master  the refill controller
//     slave   the environment (core, icache lines and memory)
// ----------------------------------------------------------------------------
interface icache_flush_ctrl_if #(
    parameter int DATABITS = 32,
    parameter int ADDRBITS = 32,
    parameter int BANKNUM  = 4,
    parameter int TTLBITS  = 8
);
    logic                       icache_rdreq;
    logic [ADDRBITS-1:0]        icache_addr;
    logic [BANKNUM-1:0]         line_miss;
    logic [BANKNUM*TTLBITS-1:0] line_ttl;

    logic [BANKNUM-1:0]         flush_mode;
    logic                       flush_we;
    logic [ADDRBITS-1:0]        flush_addr;
    logic [DATABITS-1:0]        flush_in;

    logic                       mem_rdreq;
    logic [ADDRBITS-1:0]        mem_addr;
    logic [DATABITS-1:0]        mem_rdata;
    logic                       mem_rdata_valid;

    logic                       fill_busy;
    logic                       fill_done;

    modport master (
        input  icache_rdreq, icache_addr, line_miss, line_ttl,
        input  mem_rdata, mem_rdata_valid,
        output flush_mode, flush_we, flush_addr, flush_in,
        output mem_rdreq, mem_addr,
        output fill_busy, fill_done
    );

    modport slave (
        output icache_rdreq, icache_addr, line_miss, line_ttl,
        output mem_rdata, mem_rdata_valid,
        input  flush_mode, flush_we, flush_addr, flush_in,
        input  mem_rdreq, mem_addr,
        input  fill_busy, fill_done
    );
endinterface

// File: rtl/icache_flush_ctrl.sv
// ----------------------------------------------------------------------------
// icache_flush_ctrl
//   Refill controller for BANKNUM instruction-cache lines. When a core read
//   misses in every line, the line with the highest TTL (lowest index on a tie)
//   is chosen as victim and the whole memory section containing the missing
//   address is fetched word by word and streamed into it.
//
//   Ports:
//     clk      clock
//     reset_n  asynchronous, active-low reset (aborts a fill immediately)
//     bus      icache_flush_ctrl_if.master (request, line, flush and memory
//              signals; see the interface header)
//
//   Parameters:
//     DATABITS       instruction word width
//     ADDRBITS       byte address width, equal to DATABITS
//     CACHEADDRBITS  log2(words per line); a fill is 2**CACHEADDRBITS words
//     BANKNUM        number of lines served (2 or more)
//     TTLBITS        width of each line TTL
//
//   Build option:
//     ICACHE_FILL_CRITICAL_FIRST_EN  when defined, the fill starts at the word
//       that missed and wraps round the line; otherwise it starts at word 0.
//
//   Timing: 2 cycles per word minimum; first flush_we arrives 3 cycles plus the
//   memory latency after the miss cycle.
// ----------------------------------------------------------------------------
module icache_flush_ctrl #(
    parameter int DATABITS      = 32,
    parameter int ADDRBITS      = 32,
    parameter int CACHEADDRBITS = 5,
    parameter int BANKNUM       = 4,
    parameter int TTLBITS       = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    icache_flush_ctrl_if.master  bus
);

    localparam int SECTBITS = ADDRBITS - CACHEADDRBITS - 2;
    localparam int IDXBITS  = (BANKNUM > 1) ? $clog2(BANKNUM) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_FETCH,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;

    logic [SECTBITS-1:0]        section_q;
    logic [CACHEADDRBITS-1:0]   word_q;
    logic [CACHEADDRBITS-1:0]   start_q;
    logic [CACHEADDRBITS-1:0]   end_word;
    logic [CACHEADDRBITS-1:0]   start_word;
    logic [BANKNUM*TTLBITS-1:0] ttl_q;
    logic [IDXBITS-1:0]         victim_q;
    logic [IDXBITS-1:0]         victim_sel;
    logic [TTLBITS-1:0]         best_ttl;
    logic [BANKNUM-1:0]         victim_onehot;
    logic [ADDRBITS-1:0]        addr_q;
    logic [DATABITS-1:0]        data_q;
    logic [ADDRBITS-1:0]        fetch_addr;
    logic                       fill_start;
    logic                       last_word;

`ifdef ICACHE_FILL_CRITICAL_FIRST_EN
    // Begin with the word the core is waiting for.
    assign start_word = bus.icache_addr[CACHEADDRBITS+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.icache_addr[1:0];
`else
    assign start_word = '0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.icache_addr[CACHEADDRBITS+1:0];
`endif

    // A fill is only needed when no line holds the requested section.
    assign fill_start = bus.icache_rdreq && (&bus.line_miss);

    // The word counter wraps, so the final word is the one just before the start.
    assign end_word  = start_q - CACHEADDRBITS'(1);
    assign last_word = (word_q == end_word);

    assign fetch_addr    = {section_q, word_q, 2'b00};
    assign victim_onehot = BANKNUM'(1) << victim_q;

    // Victim search over the TTLs captured at the miss: strict '>' keeps the
    // lowest index when several lines share the maximum.
    always_comb begin
        victim_sel = '0;
        best_ttl   = ttl_q[0 +: TTLBITS];
        for (int i = 1; i < BANKNUM; i++) begin
            if (ttl_q[i*TTLBITS +: TTLBITS] > best_ttl) begin
                best_ttl   = ttl_q[i*TTLBITS +: TTLBITS];
                victim_sel = IDXBITS'(i);
            end
        end
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            section_q <= '0;
            word_q    <= '0;
            start_q   <= '0;
            ttl_q     <= '0;
            victim_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Request, address and TTLs are only looked at in IDLE;
                    // capture everything the fill needs at the miss.
                    if (fill_start) begin
                        section_q <= bus.icache_addr[ADDRBITS-1:CACHEADDRBITS+2];
                        word_q    <= start_word;
                        start_q   <= start_word;
                        ttl_q     <= bus.line_ttl;
                    end
                end
                ST_SELECT: begin
                    victim_q <= victim_sel;
                end
                ST_FETCH: begin
                    if (bus.mem_rdata_valid) begin
                        data_q <= bus.mem_rdata;
                        addr_q <= fetch_addr;
                    end
                end
                ST_WRITE: begin
                    word_q <= word_q + CACHEADDRBITS'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output and next-state value gets a default before the case,
    // so no path through this block can leave a latch behind.
    always_comb begin
        state_nxt      = state;
        bus.flush_mode = '0;
        bus.flush_we   = 1'b0;
        bus.flush_addr = '0;
        bus.flush_in   = '0;
        bus.mem_rdreq  = 1'b0;
        bus.mem_addr   = '0;
        bus.fill_done  = 1'b0;
        bus.fill_busy  = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (fill_start) begin
                    state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                bus.flush_mode = victim_onehot;
                bus.mem_rdreq  = 1'b1;
                bus.mem_addr   = fetch_addr;
                if (bus.mem_rdata_valid) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus.flush_mode = victim_onehot;
                bus.flush_we   = 1'b1;
                bus.flush_addr = addr_q;
                bus.flush_in   = data_q;
                state_nxt      = last_word ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                bus.fill_done = 1'b1;
                state_nxt     = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_flush_ctrl.sv
module tb_icache_flush_ctrl;

    localparam int WORDS = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    icache_flush_ctrl_if bus ();

    icache_flush_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit          critical_first;
    int          mem_lat  = 0;
    bit          spur_en  = 1'b0;
    logic [31:0] mem_salt = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mode;
        int          cyc;
    } wr_t;
    wr_t got[$];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  miss;
        logic [31:0] ttl;
        logic [3:0]  exp_mode;
        bit          exp_fill;
        int          lat;
        bit          spur;
    } vec_t;
    vec_t vecs[6];

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] mem_fn(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ mem_salt;
    endfunction

    function automatic logic [31:0] exp_addr(logic [31:0] req, int k);
        int start;
        start = critical_first ? int'(req[6:2]) : 0;
        return {req[31:7], 7'b0} + 32'(((start + k) % WORDS) * 4);
    endfunction

    function automatic logic [3:0] exp_victim(logic [31:0] ttl);
        int mx = 0;
        for (int i = 0; i < 4; i++)
            if (int'(ttl[i*8 +: 8]) > mx) mx = int'(ttl[i*8 +: 8]);
        for (int i = 0; i < 4; i++)
            if (int'(ttl[i*8 +: 8]) == mx) return 4'(1 << i);
        return 4'b0;
    endfunction

    function automatic logic [127:0] all_outs();
        return {bus.flush_mode, bus.flush_we, bus.flush_addr, bus.flush_in,
                bus.mem_rdreq, bus.mem_addr, bus.fill_busy, bus.fill_done};
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        int          wait_cnt = 0;
        logic [31:0] req_addr = 32'h0;
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata       = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_rdreq) begin
                if (wait_cnt == 0) req_addr = bus.mem_addr;
                else check("mem_addr_stable", bus.mem_addr, req_addr);
                if (wait_cnt >= mem_lat) begin
                    bus.mem_rdata_valid = 1'b1;
                    bus.mem_rdata       = mem_fn(bus.mem_addr);
                    wait_cnt            = 0;
                end else begin
                    bus.mem_rdata_valid = 1'b0;
                    bus.mem_rdata       = $urandom;
                    wait_cnt++;
                end
            end else begin
                wait_cnt            = 0;
                bus.mem_rdata_valid = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.mem_rdata       = $urandom;
            end
        end
    end

    // ---------------- write monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && bus.flush_we)
                got.push_back('{bus.flush_addr, bus.flush_in, bus.flush_mode, cyc});
        end
    end

    // ---------------- one request, checked end to end ----------------
    task automatic run_fill(string name, logic [31:0] addr, logic [3:0] miss,
                            logic [31:0] ttl, logic [3:0] exp_mode, bit exp_fill,
                            int lat, bit spur, bit noise);
        int  c0;
        int  budget;
        bit  done;
        logic [31:0] a;
        got.delete();
        mem_lat  = lat;
        spur_en  = spur;
        mem_salt = $urandom;
        bus.icache_rdreq = 1'b1;
        bus.icache_addr  = addr;
        bus.line_miss    = miss;
        bus.line_ttl     = ttl;
        c0 = cyc;
        @(negedge clk);
        bus.icache_rdreq = noise;
        if (!exp_fill) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("%s_idle%0d", name, i), {bus.fill_busy, bus.mem_rdreq}, 2'b00);
                @(negedge clk);
            end
            check({name, "_nowrites"}, got.size(), 0);
        end else begin
            done   = 1'b0;
            budget = WORDS * (lat + 4) + 20;
            while (!done && budget > 0) begin
                if (bus.fill_done) begin
                    done = 1'b1;
                    bus.icache_rdreq = 1'b0;
                end else begin
                    if (noise) begin
                        bus.icache_addr = $urandom;
                        bus.line_miss   = 4'hF;
                        bus.line_ttl    = $urandom;
                    end
                    @(negedge clk);
                    budget--;
                end
            end
            check({name, "_done_seen"}, done, 1'b1);
            check({name, "_write_count"}, got.size(), WORDS);
            if (got.size() > 0)
                check({name, "_first_latency"}, got[0].cyc - c0, 3 + lat);
            for (int k = 0; k < got.size() && k < WORDS; k++) begin
                a = exp_addr(addr, k);
                check($sformatf("%s_w%0d", name, k),
                      {got[k].mode, got[k].addr, got[k].data},
                      {exp_mode, a, mem_fn(a)});
            end
            @(negedge clk);
            check({name, "_done_pulse"}, {bus.fill_done, bus.fill_busy}, 2'b00);
        end
        bus.icache_rdreq = 1'b0;
        bus.line_miss    = 4'h0;
        spur_en          = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int          budget;
        logic [31:0] ttl;
`ifdef ICACHE_FILL_CRITICAL_FIRST_EN
        critical_first = 1'b1;
`else
        critical_first = 1'b0;
`endif
        vecs[0] = '{32'h0000_1000, 4'hF,    32'h0109_0903, 4'b0010, 1'b1, 0, 1'b0};
        vecs[1] = '{32'h0000_1000, 4'b1011, 32'h0109_0903, 4'b0000, 1'b0, 0, 1'b0};
        vecs[2] = '{32'h0000_3000, 4'hF,    32'h0505_0505, 4'b0001, 1'b1, 5, 1'b1};
        vecs[3] = '{32'h0000_2074, 4'hF,    32'hFF00_0000, 4'b1000, 1'b1, 1, 1'b0};
        vecs[4] = '{32'h8000_0F84, 4'h0,    32'h1234_5678, 4'b0000, 1'b0, 0, 1'b1};
        vecs[5] = '{32'hFFFF_FFFC, 4'hF,    32'hC8C8_0706, 4'b0100, 1'b1, 2, 1'b0};

        reset_n          = 1'b0;
        bus.icache_rdreq = 1'b0;
        bus.icache_addr  = 32'h0;
        bus.line_miss    = 4'h0;
        bus.line_ttl     = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 128'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", all_outs(), 128'h0);

        for (int i = 0; i < 6; i++)
            run_fill($sformatf("vec%0d", i), vecs[i].addr, vecs[i].miss, vecs[i].ttl,
                     vecs[i].exp_mode, vecs[i].exp_fill, vecs[i].lat, vecs[i].spur, 1'b0);

        // New miss requests during a fill are ignored; the retry then hits.
        run_fill("busy_req", 32'h0000_5040, 4'hF, 32'h0109_0903, 4'b0010, 1'b1, 1, 1'b0, 1'b1);
        run_fill("retry_hit", 32'h0000_5040, 4'b1101, 32'h0109_0903, 4'b0000, 1'b0, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a fill, then a clean refill.
        got.delete();
        mem_lat          = 0;
        bus.icache_rdreq = 1'b1;
        bus.icache_addr  = 32'h0000_4000;
        bus.line_miss    = 4'hF;
        bus.line_ttl     = 32'h0;
        @(negedge clk);
        bus.icache_rdreq = 1'b0;
        budget = 200;
        while (got.size() < 10 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("reached_word10", got.size(), 10);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 128'h0);
        repeat (2) @(negedge clk);
        check("held_reset_outputs", all_outs(), 128'h0);
        check("no_write_in_reset", got.size(), 10);
        reset_n = 1'b1;
        @(negedge clk);
        run_fill("after_reset", 32'h0000_4000, 4'hF, 32'h0000_0000, 4'b0001, 1'b1, 2, 1'b1, 1'b0);

        // Randomized fills against the reference model.
        for (int r = 0; r < 6; r++) begin
            for (int b = 0; b < 4; b++)
                ttl[b*8 +: 8] = (r % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            run_fill($sformatf("rand%0d", r), $urandom, 4'hF, ttl, exp_victim(ttl), 1'b1,
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
